// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the CPU-side peripherals.
//   UART_ADDR            store address decoded as a UART transmit write
//   BYTE_CYCLES_DEFAULT  sysclk cycles per 10-bit UART frame at the default baud
//   tx_state_t           transmit pacing FSM states (IDLE/SEND/WAIT)
package cpu_pkg;

  localparam logic [31:0] UART_ADDR           = 32'h1000_0000;
  localparam int          BYTE_CYCLES_DEFAULT = 8680;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk, reset      clock and synchronous active-high reset
//   push, din       write din when push=1 and not full (ignored when full)
//   pop, dout       dout is the head entry; pop=1 and not empty removes it
//   full, empty     derived from the registered occupancy
//   count           registered occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is not reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the UART transmitter between CPU stores and a
// debug/trace requester. Bytes are queued and written to the UART no more
// often than once per BYTE_CYCLES sysclk cycles.
//   sysclk, cpu_reset     clock, synchronous active-high reset
//   cpu_we, cpu_data      CPU byte store; never stalls, dropped when full
//   dbg_valid, dbg_data   debug byte offer
//   dbg_ready             debug byte taken this cycle when dbg_valid=1
//   uart_wr, uart_data    one-cycle write strobe and its byte to the UART
//   fifo_full             queue holds FIFO_DEPTH entries
//   tx_idle               queue empty and pacing FSM idle (registered)
//   drop_count            dropped CPU bytes, saturating at 255
//
// Debug handshake: a byte transfers on a cycle where dbg_valid and dbg_ready
// are both 1. dbg_ready = !fifo_full & !cpu_we and may fall while dbg_valid is
// held; the requester keeps dbg_valid and dbg_data stable until the transfer.
module uart_tx_arbiter
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int BYTE_CYCLES = BYTE_CYCLES_DEFAULT
) (
  input  logic       sysclk,
  input  logic       cpu_reset,
  input  logic       cpu_we,
  input  logic [7:0] cpu_data,
  input  logic       dbg_valid,
  input  logic [7:0] dbg_data,
  output logic       dbg_ready,
  output logic       uart_wr,
  output logic [7:0] uart_data,
  output logic       fifo_full,
  output logic       tx_idle,
  output logic [7:0] drop_count
);

  localparam int            CW        = $clog2(BYTE_CYCLES);
  localparam int            OW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(BYTE_CYCLES - 2);
  localparam logic [CW-1:0] WAIT_LAST = CW'(1);

  tx_state_t     state;
  tx_state_t     state_next;
  logic [CW-1:0] cnt;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_din;
  logic [7:0]    fifo_dout;
  logic          fifo_empty;
  logic [OW-1:0] fifo_count;
  logic [OW-1:0] count_next;
  logic          cpu_drop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sysclk),
    .reset (cpu_reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign dbg_ready = !fifo_full && !cpu_we;
  assign cpu_drop  = cpu_we && fifo_full;

  // Enqueue arbiter: the CPU always wins the single write port.
  always_comb begin
    fifo_push = 1'b0;
    fifo_din  = cpu_data;
    if (cpu_we) begin
      fifo_push = !fifo_full;
      fifo_din  = cpu_data;
    end else if (dbg_valid && dbg_ready) begin
      fifo_push = 1'b1;
      fifo_din  = dbg_data;
    end
  end

  // Pacing FSM. One period is SEND (1) + WAIT (BYTE_CYCLES-2) + IDLE (1).
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        state_next = (BYTE_CYCLES == 2) ? IDLE : WAIT;
      end
      WAIT: begin
        if (cnt <= WAIT_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Occupancy after this edge, so tx_idle can be registered without lag.
  always_comb begin
    count_next = fifo_count;
    case ({fifo_push, fifo_pop})
      2'b10:   count_next = fifo_count + 1'b1;
      2'b01:   count_next = fifo_count - 1'b1;
      default: count_next = fifo_count;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      uart_wr    <= 1'b0;
      uart_data  <= 8'h00;
      drop_count <= 8'h00;
      tx_idle    <= 1'b1;
    end else begin
      state   <= state_next;
      // Strobe is the registered image of SEND, so it sits alongside the
      // byte that was registered on the pop edge.
      uart_wr <= (state == SEND);
      if (fifo_pop) uart_data <= fifo_dout;
      if (state == SEND) begin
        cnt <= WAIT_LOAD;
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end
      if (cpu_drop && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 1'b1;
      end
      tx_idle <= (count_next == '0) && (state_next == IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with FIFO_DEPTH=4, BYTE_CYCLES=20.
module tb_uart_tx_arbiter;

  localparam int FIFO_DEPTH  = 4;
  localparam int BYTE_CYCLES = 20;

  // Clock / reset
  logic       sysclk = 1'b0;
  logic       cpu_reset;
  logic       cpu_we;
  logic [7:0] cpu_data;
  logic       dbg_valid;
  logic [7:0] dbg_data;
  logic       dbg_ready;
  logic       uart_wr;
  logic [7:0] uart_data;
  logic       fifo_full;
  logic       tx_idle;
  logic [7:0] drop_count;

  always #5 sysclk = ~sysclk;

  uart_tx_arbiter #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .BYTE_CYCLES (BYTE_CYCLES)
  ) dut (
    .sysclk     (sysclk),
    .cpu_reset  (cpu_reset),
    .cpu_we     (cpu_we),
    .cpu_data   (cpu_data),
    .dbg_valid  (dbg_valid),
    .dbg_data   (dbg_data),
    .dbg_ready  (dbg_ready),
    .uart_wr    (uart_wr),
    .uart_data  (uart_data),
    .fifo_full  (fifo_full),
    .tx_idle    (tx_idle),
    .drop_count (drop_count)
  );

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // Scoreboard: expected bytes in order, observed strobes with their cycle.
  logic [7:0] exp_q[$];
  logic [7:0] obs_data_q[$];
  int         obs_cyc_q[$];

  always @(negedge sysclk) begin
    if (uart_wr) begin
      obs_data_q.push_back(uart_data);
      obs_cyc_q.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n = 0;
    while (!tx_idle && n < limit) begin
      step();
      n++;
    end
    check(tag, {31'd0, tx_idle}, 32'd1);
  endtask

  // Compares observed strobes against exp_q; strobe i must be at first_cyc + 20*i.
  task automatic check_stream(input string tag, input int first_cyc);
    int i = 0;
    check({tag, "_count"}, obs_data_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_data_q.size() > 0) begin
      check({tag, "_data"}, obs_data_q.pop_front(), exp_q.pop_front());
      check({tag, "_cycle"}, obs_cyc_q.pop_front(), first_cyc + BYTE_CYCLES * i);
      i++;
    end
    exp_q.delete();
    obs_data_q.delete();
    obs_cyc_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of sequence");
    $fatal(1, "watchdog");
  end

  int t0;

  initial begin
    cpu_reset = 1'b1;
    cpu_we    = 1'b0;
    cpu_data  = 8'h00;
    dbg_valid = 1'b0;
    dbg_data  = 8'h00;
    repeat (3) step();
    cpu_reset = 1'b0;

    // Reset state
    check("rst_uart_wr",   uart_wr,    0);
    check("rst_uart_data", uart_data,  8'h00);
    check("rst_drop",      drop_count, 0);
    check("rst_full",      fifo_full,  0);
    check("rst_tx_idle",   tx_idle,    1);
    check("rst_dbg_ready", dbg_ready,  1);

    // Single CPU byte: strobe during E2-E3, idle again at E20
    cpu_we = 1'b1; cpu_data = 8'h41;
    step(); t0 = cyc;
    cpu_we = 1'b0;
    check("s1_idle_fall", tx_idle, 0);
    step();
    check("s1_wr_e1", uart_wr, 0);
    step();
    check("s1_wr_e2", uart_wr, 1);
    check("s1_data_e2", uart_data, 8'h41);
    step();
    check("s1_wr_e3", uart_wr, 0);
    check("s1_data_hold", uart_data, 8'h41);
    repeat (16) step();
    check("s1_idle_e19", tx_idle, 0);
    step();
    check("s1_idle_e20", tx_idle, 1);
    exp_q.push_back(8'h41);
    check_stream("s1", t0 + 2);

    // Backlog pacing: 0x01..0x04 back to back
    for (int i = 1; i <= 4; i++) begin
      cpu_we = 1'b1; cpu_data = 8'(i);
      step();
      if (i == 1) t0 = cyc;
      exp_q.push_back(8'(i));
    end
    cpu_we = 1'b0;
    wait_idle(200, "s2_idle");
    check("s2_drop", drop_count, 0);
    check_stream("s2", t0 + 2);

    // Overflow: 0x10..0x16, last two dropped
    for (int i = 0; i < 5; i++) begin
      cpu_we = 1'b1; cpu_data = 8'(8'h10 + i);
      step();
      if (i == 0) t0 = cyc;
      exp_q.push_back(8'(8'h10 + i));
    end
    check("s3_full", fifo_full, 1);
    check("s3_drop0", drop_count, 0);
    cpu_data = 8'h15;
    step();
    check("s3_drop1", drop_count, 1);
    cpu_data = 8'h16;
    step();
    check("s3_drop2", drop_count, 2);
    cpu_we = 1'b0;
    check("s3_dbg_ready_full", dbg_ready, 0);
    wait_idle(400, "s3_idle");
    check("s3_not_full", fifo_full, 0);
    check_stream("s3", t0 + 2);

    // Arbitration: CPU wins, debug byte follows next cycle
    cpu_we = 1'b1; cpu_data = 8'hC0;
    dbg_valid = 1'b1; dbg_data = 8'hD0;
    #1;
    check("s4_dbg_blocked", dbg_ready, 0);
    step(); t0 = cyc;
    cpu_we = 1'b0;
    #1;
    check("s4_dbg_ready", dbg_ready, 1);
    step();
    dbg_valid = 1'b0;
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hD0);
    wait_idle(200, "s4_idle");
    check("s4_drop_kept", drop_count, 2);
    check_stream("s4", t0 + 2);

    // Reset during WAIT with a backlog
    cpu_we = 1'b1; cpu_data = 8'hA1;
    step(); t0 = cyc;
    cpu_data = 8'hA2;
    step();
    cpu_data = 8'hA3;
    step();
    cpu_we = 1'b0;
    repeat (3) step();
    exp_q.push_back(8'hA1);
    check_stream("s5_pre", t0 + 2);
    cpu_reset = 1'b1;
    step();
    cpu_reset = 1'b0;
    check("s5_wr",      uart_wr,    0);
    check("s5_data",    uart_data,  8'h00);
    check("s5_drop",    drop_count, 0);
    check("s5_tx_idle", tx_idle,    1);
    check("s5_full",    fifo_full,  0);
    repeat (60) step();
    check_stream("s5_quiet", 0);
    cpu_we = 1'b1; cpu_data = 8'h55;
    step();
    cpu_we = 1'b0;
    step();
    check("s5_wr_e1", uart_wr, 0);
    step();
    check("s5_wr_e2", uart_wr, 1);
    check("s5_data_e2", uart_data, 8'h55);
    wait_idle(200, "s5_idle");
    exp_q.delete(); obs_data_q.delete(); obs_cyc_q.delete();

    // Saturation: continuous CPU stores into a full queue
    cpu_we = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cpu_data = 8'(i);
      step();
    end
    check("s6_drop_early", drop_count, 2);
    for (int i = 7; i < 300; i++) begin
      cpu_data = 8'(i);
      step();
    end
    check("s6_drop_sat", drop_count, 8'hFF);
    repeat (20) step();
    check("s6_drop_hold", drop_count, 8'hFF);
    cpu_we = 1'b0;
    cpu_reset = 1'b1;
    step();
    cpu_reset = 1'b0;
    check("s6_drop_clear", drop_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
